// File: rtl/pll_ce_gen.sv
// pll_ce_gen: multi-channel fractional clock-enable generator driven by phase accumulators.
// Defining PLL_CE_SQUARE_EN adds the sq port with per-channel ~50% duty square waves.
module pll_ce_gen #(
  parameter int NUM_CH = 4,
  parameter int ACC_W = 32,
  parameter int LOCK_CYCLES = 16,
  parameter int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic              cfg_en,
  input  logic              sync_restart,
`ifdef PLL_CE_SQUARE_EN
  output logic [NUM_CH-1:0] sq,
`endif
  output logic [NUM_CH-1:0] ce,
  output logic              locked
);
  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
  logic [ACC_W-1:0] acc [NUM_CH];
  logic [ACC_W-1:0] inc [NUM_CH];
  logic [NUM_CH-1:0] en;
  logic [CNT_W-1:0] cnt;
  logic wr, clr;
  assign wr = cfg_we && (32'(cfg_ch) < NUM_CH);
  assign clr = wr || sync_restart;
  always_ff @(posedge refclk or posedge rst)
    if (rst) begin
      cnt <= '0;
      locked <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      locked <= 1'b0;
    end else if (!locked) begin
      if (cnt == CNT_W'(LOCK_CYCLES)) locked <= 1'b1;
      else cnt <= cnt + 1'b1;
    end
  // All accumulators are held at zero until lock, so every channel leaves zero on the same edge.
  always_ff @(posedge refclk or posedge rst)
    if (rst) begin
      en <= '0;
      ce <= '0;
`ifdef PLL_CE_SQUARE_EN
      sq <= '0;
`endif
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        inc[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr && cfg_ch == CH_W'(i)) begin
          inc[i] <= cfg_inc;
          en[i] <= cfg_en;
        end
        if (clr || !locked || !en[i]) begin
          acc[i] <= '0;
          ce[i] <= 1'b0;
`ifdef PLL_CE_SQUARE_EN
          sq[i] <= 1'b0;
`endif
        end else begin
          {ce[i], acc[i]} <= {1'b0, acc[i]} + {1'b0, inc[i]};
`ifdef PLL_CE_SQUARE_EN
          sq[i] <= acc[i][ACC_W-1];
`endif
        end
      end
    end
endmodule

// File: tb/tb_pll_ce_gen.sv
// tb_pll_ce_gen: directed self-checking bench for pll_ce_gen (4-channel and 3-channel instances).
module tb_pll_ce_gen;
  logic refclk = 1'b0;
  logic rst = 1'b1;
  logic cfg_we = 1'b0, cfg_en = 1'b0, sync_restart = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_inc = '0;
  logic c3_we = 1'b0, c3_en = 1'b0;
  logic [1:0] c3_ch = '0;
  logic [7:0] c3_inc = '0;
  logic [3:0] ce;
  logic [2:0] ce3;
  logic locked, locked3;
`ifdef PLL_CE_SQUARE_EN
  logic [3:0] sq;
  logic [2:0] sq3;
`endif
  int n_chk = 0, n_pass = 0;
  always #5 refclk = ~refclk;
  pll_ce_gen #(.NUM_CH(4), .ACC_W(8), .LOCK_CYCLES(4)) u_dut (
    .refclk(refclk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_inc(cfg_inc),
    .cfg_en(cfg_en), .sync_restart(sync_restart),
`ifdef PLL_CE_SQUARE_EN
    .sq(sq),
`endif
    .ce(ce), .locked(locked)
  );
  pll_ce_gen #(.NUM_CH(3), .ACC_W(8), .LOCK_CYCLES(4)) u_dut3 (
    .refclk(refclk), .rst(rst), .cfg_we(c3_we), .cfg_ch(c3_ch), .cfg_inc(c3_inc),
    .cfg_en(c3_en), .sync_restart(1'b0),
`ifdef PLL_CE_SQUARE_EN
    .sq(sq3),
`endif
    .ce(ce3), .locked(locked3)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge refclk);
    #1;
  endtask
  task automatic wr(input logic [1:0] ch, input logic [7:0] v, input logic e);
    cfg_we = 1'b1;
    cfg_ch = ch;
    cfg_inc = v;
    cfg_en = e;
    tick;
    cfg_we = 1'b0;
  endtask
  task automatic wait_lock;
    int n;
    n = 0;
    while (!locked && n < 20) begin
      chk("unlocked_ce", 32'(ce), 0);
      tick;
      n++;
    end
    chk("lock_cycles", n, 5);
  endtask
  initial begin
    int n, c0, c1, c2;
    logic p;
    repeat (3) @(posedge refclk);
    #1;
    chk("rst_locked", 32'(locked), 0);
    chk("rst_ce", 32'(ce), 0);
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick;
      chk("lock_seq", 32'(locked), 32'(k >= 5));
      chk("lock_seq_ce", 32'(ce), 0);
    end
    c3_we = 1'b1;
    c3_ch = 2'd0;
    c3_inc = 8'd128;
    c3_en = 1'b1;
    wr(2'd0, 8'd128, 1'b1);
    c3_we = 1'b0;
    wait_lock;
    for (int k = 1; k <= 8; k++) begin
      tick;
      chk("half_ce", 32'(ce), (k % 2 == 0) ? 32'd1 : 32'd0);
`ifdef PLL_CE_SQUARE_EN
      chk("half_sq", 32'(sq), (k % 2 == 0) ? 32'd1 : 32'd0);
`endif
    end
    wr(2'd1, 8'd85, 1'b1);
    wr(2'd2, 8'd1, 1'b1);
    wait_lock;
    c0 = 0;
    c1 = 0;
    c2 = 0;
    for (int k = 1; k <= 256; k++) begin
      tick;
      c0 += int'(ce[0]);
      c1 += int'(ce[1]);
      c2 += int'(ce[2]);
    end
    chk("frac_ch0", c0, 128);
    chk("frac_ch1", c1, 85);
    chk("frac_ch2", c2, 1);
    wr(2'd3, 8'd64, 1'b1);
    wait_lock;
    for (int k = 1; k <= 8; k++) begin
      tick;
      chk("reconf_ce30", 32'({ce[3], ce[0]}), 32'({(k % 4 == 0), (k % 2 == 0)}));
    end
    cfg_we = 1'b1;
    cfg_ch = 2'd3;
    cfg_inc = 8'd128;
    cfg_en = 1'b1;
    sync_restart = 1'b1;
    tick;
    cfg_we = 1'b0;
    sync_restart = 1'b0;
    wait_lock;
    for (int k = 1; k <= 4; k++) begin
      tick;
      chk("simul_ce3", 32'(ce[3]), 32'(k % 2 == 0));
    end
    chk("oor_pre_lock", 32'(locked3), 1);
    p = ce3[0];
    c3_we = 1'b1;
    c3_ch = 2'd3;
    c3_inc = 8'd255;
    c3_en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick;
      c3_we = 1'b0;
      p = ~p;
      chk("oor_locked", 32'(locked3), 1);
      chk("oor_ce", 32'(ce3), 32'({2'b00, p}));
    end
    n = 0;
    while (!ce[0] && n < 4) begin
      tick;
      n++;
    end
    chk("pre_rst_ce0", 32'(ce[0]), 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_ce", 32'(ce), 0);
    chk("arst_locked", 32'(locked), 0);
    chk("arst_locked3", 32'(locked3), 0);
`ifdef PLL_CE_SQUARE_EN
    chk("arst_sq", 32'(sq), 0);
`endif
    #20;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pll_ce_gen.md
Name: pll_ce_gen

Overview:
- Multi-channel fractional clock-enable generator driven from one reference clock.
- Derives NUM_CH programmable enable rates from refclk with phase accumulators, so the cores run on fewer real PLL outputs.
- Provides a PLL-style locked indication; all channels start phase-aligned when locked rises.
- Generalises a fixed four-output PLL wrapper: channel count, resolution and rates are set by parameters and a runtime configuration port.

Parameters:
- NUM_CH, 4: number of enable channels (1..16).
- ACC_W, 32: phase accumulator and increment width, in bits.
- LOCK_CYCLES, 16: refclk cycles from the last (re)configuration until locked asserts (>=1).
- CH_W, $clog2(NUM_CH) (minimum 1): width of cfg_ch. Derived; do not override.

Ports:
- refclk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  configuration write strobe, one cycle.
- cfg_ch  in  CH_W  channel index for the write.
- cfg_inc  in  ACC_W  phase increment; rate = f_refclk * cfg_inc / 2^ACC_W.
- cfg_en  in  1  channel enable.
- sync_restart  in  1  zero all accumulators and re-run the lock sequence.
- ce  out  NUM_CH  per-channel one-cycle enable pulses.
- locked  out  1  high when all ce outputs are valid.

Behaviour:
- Clock and reset: one clock, refclk. rst is asynchronous and active-high.
- While rst is high (no clock edge needed): ce=0, locked=0, every acc=0, every inc=0, every en=0, lock counter=0.
- Config write:
  - On a cycle with cfg_we=1 and cfg_ch<NUM_CH, inc[cfg_ch]<=cfg_inc and en[cfg_ch]<=cfg_en.
  - The write clears locked and the lock counter, and zeroes all accumulators.
  - If cfg_ch>=NUM_CH, the write is ignored entirely, with no effect on lock.
- sync_restart: same effect as a valid write, but with no config change.
- Simultaneous cfg_we and sync_restart: both apply, and the write is retained.
- Lock counter:
  - Runs while locked=0; it increments once per cycle, starting with the cycle after reset release, write or restart.
  - When the count reaches LOCK_CYCLES, locked<=1 on the next edge. The counter then holds.
  - locked stays 1 until the next reset, valid write or restart.
- Accumulators:
  - Each accumulator advances only when locked=1 and en[i]=1: {carry,acc[i]} <= acc[i] + inc[i], in ACC_W+1-bit arithmetic. The sum wraps modulo 2^ACC_W.
  - ce[i] is registered: ce[i] <= carry, so it is high in the cycle after the carrying update.
  - When en[i]=0 or locked=0: acc[i] holds 0 and ce[i]=0.
  - inc=0 gives no pulses.
  - Exactly inc pulses occur per 2^ACC_W locked cycles.
- Phase alignment: all accumulators leave 0 on the same edge. Let L be the first cycle in which locked=1. The first accumulator update happens at the edge ending cycle L.
- Write mid-operation: ce becomes 0 in the next cycle and locked falls. All channels resume together once relocked.

Optional Feature:
- Macro: PLL_CE_SQUARE_EN.
- Defined:
  - Adds output port sq, width NUM_CH.
  - sq[i] = registered acc[i][ACC_W-1], giving an approximately 50% duty square wave at the ce rate. It is used as a slow "clock-like" signal for legacy logic.
  - sq is 0 under reset, while unlocked, and while en[i]=0.
- Undefined: the sq port and its registers do not exist. All other behaviour is identical.

Test Plan:
Bench parameters: NUM_CH=4, ACC_W=8, LOCK_CYCLES=4.
- Reset and lock: assert rst for 3 cycles, then release with no writes -> locked=0 during cycles 1-4 after release, locked=1 from cycle 5 on, ce stays 4'b0000.
- Half rate: write ch0 inc=128 en=1 and wait for lock (cycle L) -> ce[0] is high in cycles L+2, L+4, L+6, ... and ce[3:1]=0.
- Fractional rate: ch1 inc=85 and ch2 inc=1 -> over 256 consecutive locked cycles, ce[1] gives exactly 85 pulses and ce[2] exactly 1.
- Reconfigure mid-run: with ch0 at inc=128, write ch3 inc=64 -> locked=0 and ce=0 for 5 cycles. After relock, ce[0] and ce[3] coincide every 4th cycle.
- Out-of-range and simultaneous events:
  - With NUM_CH=3 (CH_W=2), write cfg_ch=3 -> no change and locked stays 1.
  - cfg_we together with sync_restart -> the write is retained and the relock takes 5 cycles.
- Async reset mid-run: raise rst between edges -> ce=0 and locked=0 immediately, with no clock edge required. Under PLL_CE_SQUARE_EN, sq=0 as well.
